// File: rtl/dm_bridge_pkg.sv
// Shared definitions for dm_mmio_bridge: MMIO register offsets, STATUS bit
// positions, reset constants and the address-region decode helper.
package dm_bridge_pkg;

    typedef enum logic [3:0] {
        MTIME_LO_OFF    = 4'd0,
        MTIME_HI_OFF    = 4'd1,
        MTIMECMP_LO_OFF = 4'd2,
        MTIMECMP_HI_OFF = 4'd3,
        TXDATA_OFF      = 4'd4,
        STATUS_OFF      = 4'd5,
        CTRL_OFF        = 4'd6
    } reg_off_e;

    localparam int unsigned MMIO_WORDS    = 16;
    localparam int unsigned STS_EMPTY_BIT = 0;
    localparam int unsigned STS_FULL_BIT  = 1;
    localparam int unsigned STS_OVF_BIT   = 2;
    localparam int unsigned STS_CNT_LSB   = 8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic in_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && (addr < base + MMIO_WORDS);
    endfunction

    // Byte-lane merge with active-low byte enables.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  web);
        logic [31:0] r;
        r = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (!web[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with push/pop, full/empty and occupancy count. A push while
// full is accepted only when a pop happens in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dm_mmio_bridge.sv
// Data-memory port bridge: SRAM pass-through plus a 16-word MMIO window with a
// 64-bit machine timer and a byte TX FIFO. Optional macro DM_BRIDGE_PRESCALE_EN.
module dm_mmio_bridge
    import dm_bridge_pkg::*;
#(
    parameter int unsigned    AW        = 14,
    parameter logic [AW-1:0]  MMIO_BASE = 14'h3F00,
    parameter int unsigned    TXF_DEPTH = 8,
    parameter int unsigned    PRESCALE  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_oe_i,
    input  logic [AW-1:0] cpu_a_i,
    input  logic [3:0]    cpu_web_i,
    input  logic [31:0]   cpu_di_i,
    output logic [31:0]   cpu_do_o,
    output logic          sram_oe_o,
    output logic [AW-1:0] sram_a_o,
    output logic [3:0]    sram_web_o,
    output logic [31:0]   sram_di_o,
    input  logic [31:0]   sram_do_i,
    output logic          timer_irq_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i
);

    localparam int unsigned CW = $clog2(TXF_DEPTH) + 1;

    logic        mmio;
    logic [3:0]  off;
    logic        wr_any;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
    logic        wr_ctrl, wr_status, push;
    logic        mtime_wr, tick;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        timer_en_q, timer_en_d;
    logic        ovf_q, ovf_d;

    logic          fifo_full, fifo_empty, pop;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rdata;

    assign mmio   = in_mmio(32'(cpu_a_i), 32'(MMIO_BASE));
    assign off    = 4'(cpu_a_i - MMIO_BASE);
    assign wr_any = mmio & (cpu_web_i != 4'b1111);

    assign wr_mtime_lo = wr_any & (off == MTIME_LO_OFF);
    assign wr_mtime_hi = wr_any & (off == MTIME_HI_OFF);
    assign wr_cmp_lo   = wr_any & (off == MTIMECMP_LO_OFF);
    assign wr_cmp_hi   = wr_any & (off == MTIMECMP_HI_OFF);
    assign wr_status   = wr_any & (off == STATUS_OFF);
    assign wr_ctrl     = wr_any & (off == CTRL_OFF);
    assign push        = wr_any & (off == TXDATA_OFF) & ~cpu_web_i[0];
    assign mtime_wr    = wr_mtime_lo | wr_mtime_hi;

    assign sram_a_o   = cpu_a_i;
    assign sram_di_o  = cpu_di_i;
    assign sram_oe_o  = cpu_oe_i & ~mmio;
    assign sram_web_o = mmio ? 4'b1111 : cpu_web_i;

`ifdef DM_BRIDGE_PRESCALE_EN
    localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PSW-1:0] presc_q, presc_d;

    assign tick = (presc_q == PSW'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (!timer_en_q || mtime_wr || tick) presc_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) presc_q <= '0;
        else        presc_q <= presc_d;
    end
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE != 0);
    assign tick            = 1'b1;
`endif

    // A CPU write to either mtime half suppresses the increment for that cycle.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        timer_en_d = timer_en_q;
        ovf_d      = ovf_q;
        if (mtime_wr) begin
            if (wr_mtime_lo) mtime_d[31:0]  = merge_bytes(mtime_q[31:0],  cpu_di_i, cpu_web_i);
            if (wr_mtime_hi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], cpu_di_i, cpu_web_i);
        end else if (timer_en_q && tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_cmp_lo) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  cpu_di_i, cpu_web_i);
        if (wr_cmp_hi) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], cpu_di_i, cpu_web_i);
        if (wr_ctrl && !cpu_web_i[0]) timer_en_d = cpu_di_i[0];
        if (wr_status && !cpu_web_i[0] && cpu_di_i[STS_OVF_BIT]) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            timer_en_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            timer_en_q <= timer_en_d;
            ovf_q      <= ovf_d;
        end
    end

    assign timer_irq_o = timer_en_q & (mtime_q >= mtimecmp_q);

    assign pop        = ~fifo_empty & tx_ready_i;
    assign tx_valid_o = ~fifo_empty;

    tx_fifo #(
        .DEPTH (TXF_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (cpu_di_i[7:0]),
        .pop_i   (pop),
        .data_o  (tx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rdata = '0;
        case (off)
            MTIME_LO_OFF:    rdata = mtime_q[31:0];
            MTIME_HI_OFF:    rdata = mtime_q[63:32];
            MTIMECMP_LO_OFF: rdata = mtimecmp_q[31:0];
            MTIMECMP_HI_OFF: rdata = mtimecmp_q[63:32];
            STATUS_OFF: begin
                rdata[STS_EMPTY_BIT]     = fifo_empty;
                rdata[STS_FULL_BIT]      = fifo_full;
                rdata[STS_OVF_BIT]       = ovf_q;
                rdata[STS_CNT_LSB +: 8]  = 8'(fifo_count);
            end
            CTRL_OFF:        rdata[0] = timer_en_q;
            default:         rdata = '0;
        endcase
    end

    assign cpu_do_o = !mmio ? sram_do_i : (cpu_oe_i ? rdata : '0);

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Directed-vector bench for dm_mmio_bridge; read data and TX bytes are checked
// by a negedge monitor against expectation queues filled by the stimulus.
module tb_dm_mmio_bridge;

    localparam logic [13:0] BASE = 14'h3F00;

    logic        clk_i, rst_i;
    logic        cpu_oe_i;
    logic [13:0] cpu_a_i;
    logic [3:0]  cpu_web_i;
    logic [31:0] cpu_di_i, cpu_do_o;
    logic        sram_oe_o;
    logic [13:0] sram_a_o;
    logic [3:0]  sram_web_o;
    logic [31:0] sram_di_o, sram_do_i;
    logic        timer_irq_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, tx_ready_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];

    dm_mmio_bridge #(
        .AW        (14),
        .MMIO_BASE (BASE),
        .TXF_DEPTH (8),
        .PRESCALE  (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_oe_i    (cpu_oe_i),
        .cpu_a_i     (cpu_a_i),
        .cpu_web_i   (cpu_web_i),
        .cpu_di_i    (cpu_di_i),
        .cpu_do_o    (cpu_do_o),
        .sram_oe_o   (sram_oe_o),
        .sram_a_o    (sram_a_o),
        .sram_web_o  (sram_web_o),
        .sram_di_o   (sram_di_o),
        .sram_do_i   (sram_do_i),
        .timer_irq_o (timer_irq_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i && cpu_oe_i) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else                    chk("rd_data", cpu_do_o, exp_rd.pop_front());
        end
        if (tx_valid_o && tx_ready_i) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", {56'd0, tx_data_o}, 64'hFFFF);
            else                    chk("tx_data", tx_data_o, exp_tx.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cpu_oe_i  = 1'b0;
        cpu_a_i   = '0;
        cpu_web_i = 4'hF;
        cpu_di_i  = '0;
    endtask

    task automatic drv_wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] web);
        cpu_oe_i  = 1'b0;
        cpu_a_i   = a;
        cpu_di_i  = d;
        cpu_web_i = web;
    endtask

    task automatic mwr(input int unsigned o, input logic [31:0] d, input logic [3:0] web);
        drv_wr(BASE + 14'(o), d, web);
        cyc();
        idle();
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] e);
        logic in_win;
        in_win = (a >= BASE) && (a < BASE + 14'd16);
        exp_rd.push_back(e);
        cpu_oe_i  = 1'b1;
        cpu_web_i = 4'hF;
        cpu_a_i   = a;
        #1;
        chk("rd_sram_oe", sram_oe_o, !in_win);
        cyc();
        cpu_oe_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b0;
        tx_ready_i = 1'b0;
        sram_do_i  = '0;
        idle();
        #2;
        chk("rst_irq", timer_irq_o, 0);
        chk("rst_valid", tx_valid_o, 0);
        chk("rst_txdata", tx_data_o, 0);
        repeat (3) cyc();
        rst_i = 1'b1;

        rd(BASE + 14'd5, 32'h0000_0001);
        rd(BASE + 14'd6, 32'h0);
        rd(BASE + 14'd2, 32'hFFFF_FFFF);
        rd(BASE + 14'd3, 32'hFFFF_FFFF);
        rd(BASE + 14'd0, 32'h0);
        rd(BASE + 14'd4, 32'h0);
        rd(BASE + 14'd15, 32'h0);

        // SRAM pass-through and window edges
        drv_wr(14'h0010, 32'hDEAD_BEEF, 4'b0000);
        #1;
        chk("sram_web", sram_web_o, 4'b0000);
        chk("sram_a", sram_a_o, 14'h0010);
        chk("sram_di", sram_di_o, 32'hDEAD_BEEF);
        cyc();
        idle();
        sram_do_i = 32'h1234_5678;
        rd(14'h0010, 32'h1234_5678);
        rd(14'h3F10, 32'h1234_5678);
        rd(14'h3EFF, 32'h1234_5678);

        // MMIO isolation, timer enabled
        drv_wr(BASE + 14'd6, 32'h0000_00FF, 4'b0000);
        #1;
        chk("mmio_web", sram_web_o, 4'b1111);
        chk("mmio_oe", sram_oe_o, 0);
        chk("mmio_do_noe", cpu_do_o, 0);
        cyc();
        idle();
        rd(BASE, 32'd0);
        rd(BASE, 32'd1);

        // Timer compare / interrupt
        mwr(1, 32'h0, 4'b0000);
        mwr(0, 32'h0, 4'b0000);
        mwr(2, 32'd20, 4'b0000);
        mwr(3, 32'h0, 4'b0000);
        mwr(0, 32'h0, 4'b0000);
        chk("irq_t0", timer_irq_o, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("irq_t", timer_irq_o, (i >= 20));
        end
        drv_wr(BASE + 14'd6, 32'h0, 4'b0000);
        #1;
        chk("irq_before_dis", timer_irq_o, 1);
        cyc();
        idle();
        chk("irq_after_dis", timer_irq_o, 0);

        // Byte-enable write
        mwr(0, 32'h0, 4'b0000);
        mwr(0, 32'hAABB_CCDD, 4'b1101);
        rd(BASE, 32'h0000_CC00);
        rd(BASE + 14'd1, 32'h0);

        // 64-bit wrap
        mwr(1, 32'hFFFF_FFFF, 4'b0000);
        mwr(0, 32'hFFFF_FFFF, 4'b0000);
        mwr(6, 32'h1, 4'b0000);
        rd(BASE, 32'hFFFF_FFFF);
        rd(BASE + 14'd1, 32'h0);
        mwr(6, 32'h0, 4'b0000);

        // FIFO fill past full
        tx_ready_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            mwr(4, 32'(i), 4'b1110);
            if (i <= 8) exp_tx.push_back(8'(i));
        end
        rd(BASE + 14'd5, 32'h0000_0806);
        chk("full_valid", tx_valid_o, 1);
        chk("full_head", tx_data_o, 8'h01);
        mwr(5, 32'h4, 4'b1110);
        rd(BASE + 14'd5, 32'h0000_0802);
        chk("hold_head", tx_data_o, 8'h01);
        tx_ready_i = 1'b1;
        repeat (8) cyc();
        chk("drained_valid", tx_valid_o, 0);
        tx_ready_i = 1'b0;
        chk("tx_left1", exp_tx.size(), 0);

        // Full push with simultaneous pop, then reset mid-drain
        for (int i = 0; i < 8; i++) begin
            mwr(4, 32'(8'h11 + i), 4'b1110);
            exp_tx.push_back(8'(8'h11 + i));
        end
        drv_wr(BASE + 14'd4, 32'h55, 4'b1110);
        tx_ready_i = 1'b1;
        cyc();
        idle();
        tx_ready_i = 1'b0;
        exp_tx.push_back(8'h55);
        rd(BASE + 14'd5, 32'h0000_0802);
        tx_ready_i = 1'b1;
        repeat (3) cyc();
        rst_i = 1'b0;
        #1;
        chk("rst_mid_valid", tx_valid_o, 0);
        chk("rst_mid_data", tx_data_o, 0);
        tx_ready_i = 1'b0;
        exp_tx.delete();
        cyc();
        cyc();
        rst_i = 1'b1;
        rd(BASE + 14'd5, 32'h0000_0001);
        rd(BASE + 14'd2, 32'hFFFF_FFFF);

        // Push into empty: one-cycle valid latency
        tx_ready_i = 1'b1;
        exp_tx.push_back(8'h77);
        drv_wr(BASE + 14'd4, 32'h77, 4'b1110);
        #1;
        chk("lat_before", tx_valid_o, 0);
        cyc();
        idle();
        chk("lat_after", tx_valid_o, 1);
        cyc();
        chk("lat_popped", tx_valid_o, 0);
        tx_ready_i = 1'b0;
        chk("tx_left2", exp_tx.size(), 0);
        chk("rd_left", exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
